// File: rtl/gearbox_192_256_ctrl.sv
// Upstream sequencer for the 192-to-256 gearbox: owns the gearbox enable and the
// 192-bit holding slot. Each slot goes to an alignment marker, client data or idle fill.
module gearbox_192_256_ctrl #(
   parameter int unsigned    AM_PERIOD = 16384,
   parameter logic [191:0]   AM_WORD   = {24{8'hA5}},
   parameter logic [191:0]   IDLE_WORD = {24{8'h07}},
   parameter int unsigned    CNT_W     = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ctrl_enable,
   input  logic               ctrl_fill_en,
   input  logic               up_valid,
   input  logic [191:0]       up_data,
   output logic               up_take,
   output logic               gb_in_enable,
   input  logic               gb_out_idle,
   output logic [191:0]       gb_in_data,
   output logic               gb_in_datavalid,
   input  logic               dn_ready,
   output logic               gb_in_idle,
   output logic               st_running,
   output logic [CNT_W-1:0]   st_word_cnt,
   output logic [CNT_W-1:0]   st_am_cnt
);

   localparam int unsigned PER_W = (AM_PERIOD > 2) ? $clog2(AM_PERIOD) : 1;

   typedef enum logic [1:0] {S_OFF, S_START, S_RUN, S_DRAIN} state_t;

   state_t              state;
   state_t              state_nxt;
   logic                hold_vld;
   logic                hold_is_am;
   logic [191:0]        hold_data;
   logic [PER_W-1:0]    per_cnt;
   logic                am_due;

   logic                xfer;
   logic                period_end;
   logic                am_due_eff;
   logic                slot_free;
   logic                load_am;
   logic                load_client;
   logic                load_idle;
   logic                load_any;
   logic [191:0]        load_data;
   logic                start_abort;

   // Handshake: the held word is offered (gb_in_datavalid) only while the gearbox
   // reports out_idle; a word is consumed on every cycle datavalid is high.
   assign gb_in_enable    = (state != S_OFF);
   assign xfer            = hold_vld & gb_out_idle & gb_in_enable;
   assign gb_in_datavalid = xfer;
   assign gb_in_data      = hold_data;
   assign gb_in_idle      = dn_ready & gb_in_enable;
   assign st_running      = (state == S_RUN);

   // The last pre-marker word leaving makes the marker due on that same edge,
   // so it wins the refill without a bubble.
   assign period_end  = xfer & ~hold_is_am & (per_cnt == PER_W'(AM_PERIOD - 1));
   assign am_due_eff  = am_due | period_end;
   assign slot_free   = ~hold_vld | xfer;
   assign start_abort = (state == S_START) & ~ctrl_enable;

   always_comb begin
      load_am     = 1'b0;
      load_client = 1'b0;
      load_idle   = 1'b0;
      if (slot_free) begin
         case (state)
            S_START: load_am = ctrl_enable & am_due_eff;
            S_RUN: begin
               load_am     = am_due_eff;
               load_client = ~am_due_eff & up_valid;
               load_idle   = ~am_due_eff & ~up_valid & ctrl_fill_en;
            end
            S_DRAIN: load_am = am_due_eff;
            default: ;
         endcase
      end
   end

   assign load_any = load_am | load_client | load_idle;
   assign up_take  = load_client;

   always_comb begin
      load_data = IDLE_WORD;
      if (load_am)
         load_data = AM_WORD;
      else if (load_client)
         load_data = up_data;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_OFF:   if (ctrl_enable) state_nxt = S_START;
         S_START: begin
            if (!ctrl_enable)
               state_nxt = S_OFF;
            else if (xfer && hold_is_am)
               state_nxt = S_RUN;
         end
         S_RUN:   if (!ctrl_enable) state_nxt = S_DRAIN;
         S_DRAIN: if (slot_free && !load_am) state_nxt = S_OFF;
         default: state_nxt = S_OFF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= S_OFF;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_vld   <= 1'b0;
         hold_is_am <= 1'b0;
         hold_data  <= '0;
      end else if (start_abort) begin
         hold_vld   <= 1'b0;
         hold_is_am <= 1'b0;
      end else if (slot_free) begin
         hold_vld   <= load_any;
         hold_is_am <= load_am;
         if (load_any)
            hold_data <= load_data;
      end
   end

   // Marker schedule counts transfers, not cycles, so backpressure never skews it.
   always_ff @(posedge clk) begin
      if (reset) begin
         am_due  <= 1'b0;
         per_cnt <= '0;
      end else if (state == S_OFF) begin
         am_due  <= ctrl_enable;
         per_cnt <= '0;
      end else if (start_abort) begin
         am_due  <= 1'b0;
         per_cnt <= '0;
      end else begin
         if (load_am)
            am_due <= 1'b0;
         else if (period_end)
            am_due <= 1'b1;
         if (period_end)
            per_cnt <= '0;
         else if (xfer && !hold_is_am)
            per_cnt <= per_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st_word_cnt <= '0;
         st_am_cnt   <= '0;
      end else if (xfer) begin
         st_word_cnt <= st_word_cnt + 1'b1;
         if (hold_is_am)
            st_am_cnt <= st_am_cnt + 1'b1;
      end
   end

endmodule
